// File: rtl/pong_pkg.sv
// pong_pkg: shared ball types and screen/paddle geometry for the pong display pipeline
package pong_pkg;
    localparam int ACTIVE_ROWS = 480;
    localparam int ACTIVE_COLS = 640;
    localparam int PADDLE_W    = 8;
    localparam int PADDLE_H    = 64;
    localparam int ROW_W       = $clog2(ACTIVE_ROWS);
    localparam int COL_W       = $clog2(ACTIVE_COLS);
    typedef enum logic [1:0] {SERVE, PLAY, MISS} ball_state_t;
    typedef struct packed {
        logic dx_right;
        logic dy_down;
    } ball_dir_t;
endpackage

// File: rtl/pong_ball_engine_if.sv
// pong_ball_if: scan position, paddle and pause inputs plus ball position/mask/score outputs
interface pong_ball_if #(
    parameter int ROW_W = pong_pkg::ROW_W,
    parameter int COL_W = pong_pkg::COL_W
);
    logic             pause;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] pad_l_y;
    logic [ROW_W-1:0] pad_r_y;
    logic             ball_present;
    logic [COL_W-1:0] x_pos;
    logic [ROW_W-1:0] y_pos;
    logic             score_l;
    logic             score_r;
    modport master (
        output pause, row, col, pad_l_y, pad_r_y,
        input  ball_present, x_pos, y_pos, score_l, score_r
    );
    modport slave (
        input  pause, row, col, pad_l_y, pad_r_y,
        output ball_present, x_pos, y_pos, score_l, score_r
    );
endinterface

// File: rtl/pong_ball_engine_move_tick_gen.sv
// move_tick_gen: wrapping move counter that emits a one-cycle tick, frozen while paused
module move_tick_gen #(
    parameter int CLKS_PER_MOVE = 250_000
) (
    input  logic clk,
    input  logic rst,
    input  logic pause,
    output logic tick
);
    localparam int CNT_W = $clog2(CLKS_PER_MOVE);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_MOVE - 1);
    logic [CNT_W-1:0] cnt;
    // count 0..CLKS_PER_MOVE-1 and wrap; pause holds the count
    always_ff @(posedge clk)
        if (rst) cnt <= '0;
        else if (!pause) cnt <= tick ? '0 : cnt + 1'b1;
    assign tick = !pause && cnt == LAST;
endmodule

// File: rtl/pong_ball_engine.sv
// pong_ball_engine: serve/play/miss ball FSM with wall and paddle bounces and per-pixel mask
module pong_ball_engine #(
    parameter int CLKS_PER_MOVE = 250_000,
    parameter int ACTIVE_ROWS   = pong_pkg::ACTIVE_ROWS,
    parameter int ACTIVE_COLS   = pong_pkg::ACTIVE_COLS,
    parameter int SIDE_LEN      = 16,
    parameter int STEP          = 1,
    parameter int PADDLE_W      = pong_pkg::PADDLE_W,
    parameter int PADDLE_H      = pong_pkg::PADDLE_H,
    parameter int SERVE_TICKS   = 120
) (
    input logic        clk,
    input logic        rst,
    pong_ball_if.slave bus
);
    import pong_pkg::*;
    localparam int RW = $clog2(ACTIVE_ROWS);
    localparam int CW = $clog2(ACTIVE_COLS);
    localparam int W  = CW + 1;
    localparam int SW = $clog2(SERVE_TICKS) + 1;
    localparam logic [CW-1:0] X_C        = CW'(ACTIVE_COLS / 2 - SIDE_LEN / 2);
    localparam logic [RW-1:0] Y_C        = RW'(ACTIVE_ROWS / 2 - SIDE_LEN / 2);
    localparam logic [W-1:0]  X_MIN      = W'(PADDLE_W);
    localparam logic [W-1:0]  X_MAX      = W'(ACTIVE_COLS - PADDLE_W - SIDE_LEN);
    localparam logic [W-1:0]  Y_MAX      = W'(ACTIVE_ROWS - SIDE_LEN);
    localparam logic [W-1:0]  STP        = W'(STEP);
    localparam logic [W-1:0]  SL         = W'(SIDE_LEN);
    localparam logic [W-1:0]  PH         = W'(PADDLE_H);
    localparam logic [SW-1:0] SERVE_LAST = SW'(SERVE_TICKS - 1);

    ball_state_t   state, state_nx;
    ball_dir_t     dir, dir_nx;
    logic [SW-1:0] serve_cnt, serve_cnt_nx;
    logic [CW-1:0] x, x_nx;
    logic [RW-1:0] y, y_nx;
    logic          serve_dy, serve_dy_nx;
    logic          tick, serve_done, in_play;
    logic [W-1:0]  xw, yw, pl, pr, rw, cw, x_mv, y_mv;
    logic          y_lo, y_hi, dy_mv, at_edge, hit, lost;

    move_tick_gen #(.CLKS_PER_MOVE(CLKS_PER_MOVE)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .pause(bus.pause),
        .tick (tick)
    );

    // widen everything so ball+side and paddle+height sums never wrap
    assign xw = W'(x);
    assign yw = W'(y);
    assign pl = W'(bus.pad_l_y);
    assign pr = W'(bus.pad_r_y);
    assign rw = W'(bus.row);
    assign cw = W'(bus.col);

    // state and datapath registers; pause freezes everything
    always_ff @(posedge clk)
        if (rst) begin
            state     <= SERVE;
            serve_cnt <= '0;
            x         <= X_C;
            y         <= Y_C;
            dir       <= '{dx_right: 1'b1, dy_down: 1'b1};
            serve_dy  <= 1'b1;
        end else if (!bus.pause) begin
            state     <= state_nx;
            serve_cnt <= serve_cnt_nx;
            x         <= x_nx;
            y         <= y_nx;
            dir       <= dir_nx;
            serve_dy  <= serve_dy_nx;
        end

    // next state: serve countdown, play until a paddle miss, miss lasts one cycle
    always_comb begin
        serve_done = serve_cnt == SERVE_LAST;
        state_nx   = state == MISS ? SERVE :
                     !tick         ? state :
                     state == SERVE ? (serve_done ? PLAY : SERVE) :
                     (lost ? MISS : PLAY);
    end

    // move datapath: both axes resolved from the current position in the same tick
    always_comb begin
        y_lo         = yw < STP;
        y_hi         = yw + STP > Y_MAX;
        y_mv         = dir.dy_down ? (y_hi ? Y_MAX : yw + STP) : (y_lo ? '0 : yw - STP);
        dy_mv        = dir.dy_down ? !y_hi : y_lo;
        at_edge      = dir.dx_right ? xw + STP >= X_MAX : xw <= X_MIN + STP;
        hit          = dir.dx_right ? (yw < pr + PH && yw + SL > pr) : (yw < pl + PH && yw + SL > pl);
        x_mv         = at_edge ? (dir.dx_right ? X_MAX : X_MIN) : (dir.dx_right ? xw + STP : xw - STP);
        lost         = at_edge && !hit;
        in_play      = state == PLAY && tick;
        serve_cnt_nx = state == SERVE && tick ? (serve_done ? '0 : serve_cnt + 1'b1) : serve_cnt;
        x_nx         = state == MISS ? X_C : in_play && !lost ? CW'(x_mv) : x;
        y_nx         = state == MISS ? Y_C : in_play ? RW'(y_mv) : y;
        serve_dy_nx  = state == MISS ? !serve_dy : serve_dy;
        dir_nx.dx_right = in_play && at_edge && hit ? !dir.dx_right : dir.dx_right;
        dir_nx.dy_down  = state == MISS ? !serve_dy : in_play ? dy_mv : dir.dy_down;
    end

    // outputs: score pulse while in MISS (dx already points at the conceding side), pixel mask
    always_comb begin
        bus.score_l      = state == MISS && !bus.pause && dir.dx_right;
        bus.score_r      = state == MISS && !bus.pause && !dir.dx_right;
        bus.ball_present = rw >= yw && rw < yw + SL && cw >= xw && cw < xw + SL;
    end

    assign bus.x_pos = x;
    assign bus.y_pos = y;
endmodule

// File: tb/tb_pong_ball_engine.sv
// tb_pong_ball_engine: random play of STEP=1 and STEP=3 balls against an integer rules model
module tb_pong_ball_engine;
    localparam int CPM = 4, ST = 2, SL = 16, PW = 8, PH = 64, ROWS = 480, COLS = 640;
    localparam int XC = COLS / 2 - SL / 2, YC = ROWS / 2 - SL / 2;
    localparam int NCYC = 20000;

    typedef struct {
        int cnt, ph, sc, x, y, dxr, dyd, sdy;
    } ball_m_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0, errors = 0;
    ball_m_t m1, m3, t;
    bit p, did_rst;
    int pl1, pr1, pl3, pr3, r1, c1, r3, c3, n_score1, n_score3;

    always #5 clk = ~clk;

    pong_ball_if bus1 ();
    pong_ball_if bus3 ();

    pong_ball_engine #(.CLKS_PER_MOVE(CPM), .SERVE_TICKS(ST), .STEP(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );
    pong_ball_engine #(.CLKS_PER_MOVE(CPM), .SERVE_TICKS(ST), .STEP(3)) dut3 (
        .clk(clk), .rst(rst), .bus(bus3)
    );

    task automatic check(string tag, logic [31:0] got, int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // one clock of the game rules; ph 0=serve 1=play 2=miss
    function automatic ball_m_t m_next(ball_m_t m, bit r, bit pz, int pl, int pr, int step);
        ball_m_t n = m;
        int pad;
        bit hit_pad;
        if (r) return '{0, 0, 0, XC, YC, 1, 1, 1};
        if (pz) return m;
        n.cnt = (m.cnt + 1) % CPM;
        if (m.ph == 2) begin
            n.ph = 0; n.x = XC; n.y = YC; n.sdy = !m.sdy; n.dyd = !m.sdy;
        end else if (m.cnt == CPM - 1 && m.ph == 0) begin
            if (m.sc == ST - 1) begin n.ph = 1; n.sc = 0; end
            else n.sc = m.sc + 1;
        end else if (m.cnt == CPM - 1) begin
            if (m.dyd) begin
                if (m.y + step > ROWS - SL) begin n.y = ROWS - SL; n.dyd = 0; end
                else n.y = m.y + step;
            end else begin
                if (m.y < step) begin n.y = 0; n.dyd = 1; end
                else n.y = m.y - step;
            end
            pad = m.dxr ? pr : pl;
            hit_pad = m.y < pad + PH && m.y + SL > pad;
            if (m.dxr ? m.x + step >= COLS - PW - SL : m.x - step <= PW) begin
                if (!hit_pad) n.ph = 2;
                else begin n.x = m.dxr ? COLS - PW - SL : PW; n.dxr = !m.dxr; end
            end else n.x = m.dxr ? m.x + step : m.x - step;
        end
        return n;
    endfunction

    function automatic int clip(int v, int hi);
        return v < 0 ? 0 : v > hi ? hi : v;
    endfunction

    function automatic int pick_pad(int y);
        return $urandom_range(0, 9) < 6 ? clip(y + 15 - int'($urandom_range(0, 78)), 511)
                                        : int'($urandom_range(0, 511));
    endfunction

    function automatic int pick_near(int base, int hi);
        return $urandom_range(0, 1) == 1 ? clip(base - 1 + int'($urandom_range(0, 17)), hi)
                                         : int'($urandom_range(0, hi));
    endfunction

    task automatic check_ball(string nm, ball_m_t m, logic [9:0] gx, logic [8:0] gy,
                              logic gl, logic gr, logic gp, int r, int c, bit pz);
        check({nm, " x_pos"}, gx, m.x);
        check({nm, " y_pos"}, gy, m.y);
        check({nm, " score_l"}, gl, int'(m.ph == 2 && !pz && m.dxr == 1));
        check({nm, " score_r"}, gr, int'(m.ph == 2 && !pz && m.dxr == 0));
        check({nm, " present"}, gp, int'(r >= m.y && r < m.y + SL && c >= m.x && c < m.x + SL));
    endtask

    task automatic drive();
        bus1.pause = p;  bus3.pause = p;
        bus1.pad_l_y = 9'(pl1); bus1.pad_r_y = 9'(pr1);
        bus3.pad_l_y = 9'(pl3); bus3.pad_r_y = 9'(pr3);
        bus1.row = 9'(r1); bus1.col = 10'(c1);
        bus3.row = 9'(r3); bus3.col = 10'(c3);
    endtask

    initial begin
        p = 0; pl1 = 0; pr1 = 0; pl3 = 0; pr3 = 0; r1 = 0; c1 = 0; r3 = 0; c3 = 0;
        did_rst = 0; n_score1 = 0; n_score3 = 0;
        drive();
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            m1 = m_next(m1, rst, p, pl1, pr1, 1);
            m3 = m_next(m3, rst, p, pl3, pr3, 3);
            #1;
            p   = (cyc >= 600 && cyc < 620) || (cyc > 1000 && $urandom_range(0, 39) == 0);
            pl1 = pick_pad(m1.y); pr1 = pick_pad(m1.y);
            pl3 = pick_pad(m3.y); pr3 = pick_pad(m3.y);
            r1  = pick_near(m1.y, 511); c1 = pick_near(m1.x, 1023);
            r3  = pick_near(m3.y, 511); c3 = pick_near(m3.x, 1023);
            rst = cyc < 2;
            if (!did_rst && cyc > 2) begin
                t = m_next(m3, 0, p, pl3, pr3, 3);
                if (t.ph == 2 && m3.ph == 1) begin
                    rst = 1;
                    did_rst = 1;
                end
            end
            drive();
            #1;
            check_ball("s1", m1, bus1.x_pos, bus1.y_pos, bus1.score_l, bus1.score_r,
                       bus1.ball_present, r1, c1, p);
            check_ball("s3", m3, bus3.x_pos, bus3.y_pos, bus3.score_l, bus3.score_r,
                       bus3.ball_present, r3, c3, p);
            n_score1 += int'(bus1.score_l | bus1.score_r);
            n_score3 += int'(bus3.score_l | bus3.score_r);
        end
        check("reset at miss hit", 32'(did_rst), 1);
        check("s1 score seen", 32'(n_score1 > 0), 1);
        check("s3 score seen", 32'(n_score3 > 0), 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
